neuron_sweep_scheduler: RTL and testbench

Timestep sequencer for the membrane-potential SRAM (`sram`, single-port, registered read, one word per neuron). On each timestep `start` pulse it sweeps every neuron address and performs a leaky-integrate-and-fire read-modify-write on each one:

- read the potential;
- apply leak and synaptic current, saturating;
- threshold-compare, then write back either the updated or the reset potential;
- on a threshold crossing, emit a spike event over a valid/ready handshake.

It is the sole master of the SRAM's address, write-enable and write-data ports.

---
 rtl/neuron_pkg.sv | 35 +++
 rtl/lif_update.sv | 46 ++++
 rtl/neuron_sweep_scheduler.sv | 147 ++++++++++++++
 tb/tb_neuron_sweep_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// neuron_pkg
// Shared definitions for the membrane-potential sweep logic:
//   sweep_state_t  - states of the timestep sweep sequencer
//   NEURON_IDX_W   - neuron index width for the default neuron count
//   sat_signed()   - clamps a wide signed value into a signed range of a given width
package neuron_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_SPIKE,
      ST_DONE
   } sweep_state_t;

   localparam int DEFAULT_DEPTH = 256;
   localparam int NEURON_IDX_W  = $clog2(DEFAULT_DEPTH);

   // Clamp 'value' into [-(2^(width-1)), 2^(width-1)-1]; the caller truncates
   // the result to 'width' bits, which is then lossless.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int width);
      logic signed [63:0] maxVal;
      logic signed [63:0] minVal;
      maxVal = (64'sd1 <<< (width - 1)) - 64'sd1;
      minVal = -(64'sd1 <<< (width - 1));
      if (value > maxVal)
         return maxVal;
      else if (value < minVal)
         return minVal;
      else
         return value;
   endfunction

endpackage

// File: rtl/lif_update.sv
// lif_update
// Combinational leaky-integrate-and-fire step for one neuron.
//   v        in   WIDTH signed  current membrane potential
//   current  in   WIDTH signed  synaptic input current
//   v_next   out  WIDTH signed  sat(v - (v >>> LEAK_SHIFT) + current)
//   fire     out  1             v_next has reached THRESHOLD
module lif_update
   import neuron_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int THRESHOLD  = 1000,
   parameter int V_RESET    = 0,
   parameter int LEAK_SHIFT = 4
) (
   input  logic signed [WIDTH-1:0] v,
   input  logic signed [WIDTH-1:0] current,
   output logic signed [WIDTH-1:0] v_next,
   output logic                    fire
);

   // Two guard bits are enough: |v - v/2^k| < 2^WIDTH and adding one more
   // WIDTH-bit operand stays inside WIDTH+2 signed bits.
   localparam int EXT_W = WIDTH + 2;
   localparam logic signed [WIDTH-1:0] THR = WIDTH'(THRESHOLD);

   logic signed [EXT_W-1:0] vExt;
   logic signed [EXT_W-1:0] leakExt;
   logic signed [EXT_W-1:0] curExt;
   logic signed [EXT_W-1:0] sumExt;

   // Reset potential is applied by the sequencer, not here; this block only
   // decides whether the neuron fires.
   logic unusedReset;
   assign unusedReset = (V_RESET != 0);

   // Leak and integrate at extended width, then clamp back to the word range.
   always_comb begin
      vExt    = EXT_W'(v);
      curExt  = EXT_W'(current);
      leakExt = vExt >>> LEAK_SHIFT;
      sumExt  = vExt - leakExt + curExt;
      v_next  = WIDTH'(sat_signed(64'(sumExt), WIDTH));
      fire    = (v_next >= THR);
   end

endmodule

// File: rtl/neuron_sweep_scheduler.sv
// neuron_sweep_scheduler
// On each timestep tick, walks every neuron address of the potential SRAM and
// performs a read / leak-integrate / threshold / write-back sequence, raising
// a spike event (valid/ready) whenever a neuron fires.
//   clk, reset    clock, asynchronous active-high reset
//   start         timestep tick, accepted only when idle
//   busy          sweep in progress (READ/WRITE/SPIKE)
//   done          one-cycle pulse at the end of a sweep
//   overrun       one-cycle pulse when a tick arrives while not idle (dropped)
//   sram_*        sole master of the single-port, registered-read SRAM
//   syn_addr      neuron whose synaptic current is requested
//   syn_current   combinational current for syn_addr
//   spike_*       spike event handshake, spike_addr held while valid
module neuron_sweep_scheduler
   import neuron_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 256,
   parameter int THRESHOLD  = 1000,
   parameter int V_RESET    = 0,
   parameter int LEAK_SHIFT = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     overrun,
   output logic                     sram_we,
   output logic [$clog2(DEPTH)-1:0] sram_addr,
   output logic signed [WIDTH-1:0]  sram_wdata,
   input  logic signed [WIDTH-1:0]  sram_rdata,
   output logic [$clog2(DEPTH)-1:0] syn_addr,
   input  logic signed [WIDTH-1:0]  syn_current,
   output logic                     spike_valid,
   input  logic                     spike_ready,
   output logic [$clog2(DEPTH)-1:0] spike_addr
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic signed [WIDTH-1:0] VRST = WIDTH'(V_RESET);

   sweep_state_t state_q, state_d;
   logic [IDX_W-1:0] n_q, n_d;
   logic [IDX_W-1:0] spikeAddr_q, spikeAddr_d;

   logic signed [WIDTH-1:0] vNext;
   logic fire;

   lif_update #(
      .WIDTH      (WIDTH),
      .THRESHOLD  (THRESHOLD),
      .V_RESET    (V_RESET),
      .LEAK_SHIFT (LEAK_SHIFT)
   ) u_lif (
      .v       (sram_rdata),
      .current (syn_current),
      .v_next  (vNext),
      .fire    (fire)
   );

   // State, neuron index and latched spike address; reset abandons any sweep.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         n_q         <= '0;
         spikeAddr_q <= '0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         spikeAddr_q <= spikeAddr_d;
      end
   end

   // Next-state and output decode. The write-back in WRITE happens whether or
   // not the neuron fires, so spike backpressure never delays the SRAM update;
   // it only holds the sequencer in SPIKE before the next neuron.
   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      spikeAddr_d = spikeAddr_q;
      busy        = 1'b0;
      done        = 1'b0;
      sram_we     = 1'b0;
      sram_wdata  = '0;
      spike_valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               n_d     = '0;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            busy    = 1'b1;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            busy    = 1'b1;
            sram_we = 1'b1;
            if (fire) begin
               sram_wdata  = VRST;
               spikeAddr_d = n_q;
               state_d     = ST_SPIKE;
            end else begin
               sram_wdata = vNext;
               if (n_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  n_d     = n_q + 1'b1;
                  state_d = ST_READ;
               end
            end
         end
         ST_SPIKE: begin
            busy        = 1'b1;
            spike_valid = 1'b1;
            if (spike_ready) begin
               if (n_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  n_d     = n_q + 1'b1;
                  state_d = ST_READ;
               end
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Address ports simply follow the index; ticks outside IDLE are flagged.
   always_comb begin
      sram_addr  = n_q;
      syn_addr   = n_q;
      spike_addr = spikeAddr_q;
      overrun    = start && (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_neuron_sweep_scheduler.sv
// tb_neuron_sweep_scheduler
// Directed bench: two scheduler instances (THRESHOLD=100 and THRESHOLD=32767,
// WIDTH=16, DEPTH=4, LEAK_SHIFT=2) each attached to a behavioural
// registered-read SRAM. 'sel' chooses which instance a sweep drives/observes.
module tb_neuron_sweep_scheduler;

   localparam int W  = 16;
   localparam int D  = 4;
   localparam int AW = 2;
   localparam int SWEEP_CYCLES = 20;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic sel;
   logic spikeReady;
   logic signed [W-1:0] synCurrent;

   logic startA, startB;
   logic busyA, doneA, ovA, weA, svA;
   logic busyB, doneB, ovB, weB, svB;
   logic [AW-1:0] addrA, synA, saA, addrB, synB, saB;
   logic signed [W-1:0] wdataA, rdataA, wdataB, rdataB;

   logic busyO, doneO, ovO, weO, svO;
   logic [AW-1:0] addrO, synO, saO;
   logic signed [W-1:0] wdataO;

   logic loadEn, loadSel;
   logic [AW-1:0] loadAddr;
   logic signed [W-1:0] loadData;
   logic signed [W-1:0] memA [D];
   logic signed [W-1:0] memB [D];

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   int ovCyc, rlStart, rlEnd, rstCyc;
   int doneCyc, doneCount, busyCount, svCount, stableErr, stallWe;
   int hsCount, ovFirst, ovCount, wrCount, firstWrAddr;
   int hsAddr [8];
   logic busyAtDone, rstOr;

   always #5 clk = ~clk;

   assign startA = start & ~sel;
   assign startB = start & sel;

   assign busyO  = sel ? busyB  : busyA;
   assign doneO  = sel ? doneB  : doneA;
   assign ovO    = sel ? ovB    : ovA;
   assign weO    = sel ? weB    : weA;
   assign svO    = sel ? svB    : svA;
   assign addrO  = sel ? addrB  : addrA;
   assign synO   = sel ? synB   : synA;
   assign saO    = sel ? saB    : saA;
   assign wdataO = sel ? wdataB : wdataA;

   neuron_sweep_scheduler #(
      .WIDTH(W), .DEPTH(D), .THRESHOLD(100), .V_RESET(0), .LEAK_SHIFT(2)
   ) dutA (
      .clk(clk), .reset(reset), .start(startA), .busy(busyA), .done(doneA),
      .overrun(ovA), .sram_we(weA), .sram_addr(addrA), .sram_wdata(wdataA),
      .sram_rdata(rdataA), .syn_addr(synA), .syn_current(synCurrent),
      .spike_valid(svA), .spike_ready(spikeReady), .spike_addr(saA)
   );

   neuron_sweep_scheduler #(
      .WIDTH(W), .DEPTH(D), .THRESHOLD(32767), .V_RESET(0), .LEAK_SHIFT(2)
   ) dutB (
      .clk(clk), .reset(reset), .start(startB), .busy(busyB), .done(doneB),
      .overrun(ovB), .sram_we(weB), .sram_addr(addrB), .sram_wdata(wdataB),
      .sram_rdata(rdataB), .syn_addr(synB), .syn_current(synCurrent),
      .spike_valid(svB), .spike_ready(spikeReady), .spike_addr(saB)
   );

   // Behavioural single-port SRAMs with registered read and their own reset;
   // the load port lets the bench preset potentials while the DUTs are idle.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < D; i++) begin
            memA[i] <= '0;
            memB[i] <= '0;
         end
         rdataA <= '0;
         rdataB <= '0;
      end else begin
         if (loadEn) begin
            if (loadSel) memB[loadAddr] <= loadData;
            else         memA[loadAddr] <= loadData;
         end else begin
            if (weA) memA[addrA] <= wdataA;
            if (weB) memB[addrB] <= wdataB;
         end
         rdataA <= memA[addrA];
         rdataB <= memB[addrB];
      end
   end

   // Compare and tally one observed value against its hand-computed value.
   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic loadAll(input logic s, input logic signed [W-1:0] v0,
                          input logic signed [W-1:0] v1, input logic signed [W-1:0] v2,
                          input logic signed [W-1:0] v3);
      logic signed [W-1:0] vals [4];
      vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
      for (int i = 0; i < D; i++) begin
         loadEn   = 1'b1;
         loadSel  = s;
         loadAddr = AW'(i);
         loadData = vals[i];
         @(posedge clk); #1;
      end
      loadEn = 1'b0;
   endtask

   // Runs a fixed window of cycles; cycle 0 carries the start pulse. Inputs are
   // driven 1 time unit after the edge and outputs sampled 1 unit later.
   task automatic applyStimulus();
      logic prevSv, prevHs, hs;
      logic [AW-1:0] prevSa;
      doneCyc = -1; doneCount = 0; busyCount = 0; svCount = 0; stableErr = 0;
      stallWe = 0; hsCount = 0; ovFirst = -1; ovCount = 0; wrCount = 0;
      firstWrAddr = -1; busyAtDone = 1'b1; rstOr = 1'b1;
      prevSv = 1'b0; prevHs = 1'b0; prevSa = '0;
      for (int c = 0; c < SWEEP_CYCLES; c++) begin
         start      = (c == 0) || (c == ovCyc);
         spikeReady = !((c >= rlStart) && (c <= rlEnd));
         reset      = (c == rstCyc);
         #1;
         if (reset)
            rstOr = busyO | doneO | ovO | weO | (|addrO) | (|wdataO) | (|synO) | svO | (|saO);
         if (doneO) begin
            doneCount++;
            if (doneCyc < 0) begin
               doneCyc    = c;
               busyAtDone = busyO;
            end
         end
         if (busyO) busyCount++;
         if (ovO) begin
            ovCount++;
            if (ovFirst < 0) ovFirst = c;
         end
         if (weO) begin
            if (firstWrAddr < 0) firstWrAddr = int'(addrO);
            wrCount++;
         end
         if (svO) begin
            svCount++;
            if (weO) stallWe++;
            if (prevSv && !prevHs && (saO != prevSa)) stableErr++;
         end
         hs = svO && spikeReady;
         if (hs && hsCount < 8) begin
            hsAddr[hsCount] = int'(saO);
            hsCount++;
         end
         prevSv = svO; prevSa = saO; prevHs = hs;
         @(posedge clk); #1;
      end
      start = 1'b0; reset = 1'b0; spikeReady = 1'b1;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; sel = 1'b0; spikeReady = 1'b1; synCurrent = '0;
      loadEn = 1'b0; loadSel = 1'b0; loadAddr = '0; loadData = '0;
      ovCyc = -1; rlStart = -1; rlEnd = -2; rstCyc = -1;
      repeat (2) @(posedge clk);
      #1;

      // Reset state: every output low
      checkOutput("reset busy", busyA, 0);
      checkOutput("reset done", doneA, 0);
      checkOutput("reset overrun", ovA, 0);
      checkOutput("reset sram_we", weA, 0);
      checkOutput("reset sram_addr", addrA, 0);
      checkOutput("reset sram_wdata", wdataA, 0);
      checkOutput("reset syn_addr", synA, 0);
      checkOutput("reset spike_valid", svA, 0);
      checkOutput("reset spike_addr", saA, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Basic sweep: 0 + 10 everywhere, done in cycle 9
      $display("[TB] basic sweep");
      synCurrent = 16'sd10;
      loadAll(1'b0, 0, 0, 0, 0);
      applyStimulus();
      checkOutput("basic mem0", memA[0], 10);
      checkOutput("basic mem3", memA[3], 10);
      checkOutput("basic writes", wrCount, 4);
      checkOutput("basic first write addr", firstWrAddr, 0);
      checkOutput("basic spike_valid cycles", svCount, 0);
      checkOutput("basic done cycle", doneCyc, 9);
      checkOutput("basic done count", doneCount, 1);
      checkOutput("basic busy cycles", busyCount, 8);
      checkOutput("basic busy at done", busyAtDone, 0);
      checkOutput("basic overrun", ovCount, 0);

      // Threshold crossing at neuron 2: 96 - 24 + 30 = 102 -> reset to 0
      $display("[TB] threshold crossing");
      synCurrent = 16'sd30;
      loadAll(1'b0, 0, 0, 96, 0);
      applyStimulus();
      checkOutput("thr mem0", memA[0], 30);
      checkOutput("thr mem2", memA[2], 0);
      checkOutput("thr mem3", memA[3], 30);
      checkOutput("thr spike_valid cycles", svCount, 1);
      checkOutput("thr handshakes", hsCount, 1);
      checkOutput("thr spike_addr", hsAddr[0], 2);
      checkOutput("thr done cycle", doneCyc, 10);

      // Backpressure: ready low for cycles 7..11 while the spike is pending
      $display("[TB] backpressure");
      loadAll(1'b0, 0, 0, 96, 0);
      rlStart = 7; rlEnd = 11;
      applyStimulus();
      rlStart = -1; rlEnd = -2;
      checkOutput("bp spike_valid cycles", svCount, 6);
      checkOutput("bp spike_addr stable", stableErr, 0);
      checkOutput("bp we while stalled", stallWe, 0);
      checkOutput("bp handshakes", hsCount, 1);
      checkOutput("bp spike_addr", hsAddr[0], 2);
      checkOutput("bp mem2", memA[2], 0);
      checkOutput("bp done cycle", doneCyc, 15);

      // Negative saturation: -32768 + 8192 - 32768 clamps to -32768
      $display("[TB] negative saturation");
      synCurrent = -16'sd32768;
      loadAll(1'b0, -16'sd32768, 0, 0, 0);
      applyStimulus();
      checkOutput("negsat mem0", memA[0], -32768);
      checkOutput("negsat mem1", memA[1], -32768);
      checkOutput("negsat spikes", svCount, 0);

      // Positive saturation with THRESHOLD=32767: every neuron reaches 32767
      // (neuron 1 only through clamping) and fires, so each is written 0.
      $display("[TB] positive saturation");
      sel = 1'b1;
      synCurrent = 16'sd32767;
      loadAll(1'b1, 0, 16'sd32767, 0, 0);
      applyStimulus();
      checkOutput("possat handshakes", hsCount, 4);
      checkOutput("possat second spike addr", hsAddr[1], 1);
      checkOutput("possat mem1", memB[1], 0);
      checkOutput("possat done cycle", doneCyc, 13);
      sel = 1'b0;

      // Overrun: extra start in cycle 4 is flagged and dropped
      $display("[TB] overrun");
      synCurrent = 16'sd10;
      loadAll(1'b0, 0, 0, 0, 0);
      ovCyc = 4;
      applyStimulus();
      ovCyc = -1;
      checkOutput("ovr overrun cycle", ovFirst, 4);
      checkOutput("ovr overrun count", ovCount, 1);
      checkOutput("ovr done count", doneCount, 1);
      checkOutput("ovr done cycle", doneCyc, 9);
      checkOutput("ovr mem2", memA[2], 10);

      // Mid-sweep reset in cycle 5, then a fresh sweep from address 0
      $display("[TB] mid-sweep reset");
      loadAll(1'b0, 0, 0, 0, 0);
      rstCyc = 5;
      applyStimulus();
      rstCyc = -1;
      checkOutput("rst outputs during reset", rstOr, 0);
      checkOutput("rst done count", doneCount, 0);
      checkOutput("rst writes before reset", wrCount, 2);
      applyStimulus();
      checkOutput("rst fresh first write addr", firstWrAddr, 0);
      checkOutput("rst fresh done cycle", doneCyc, 9);
      checkOutput("rst fresh mem3", memA[3], 10);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
